// File: rtl/port_rx_pkg.sv
// Shared definitions for the receive front end.
// Contents: receive FSM state enum, frame length limits, SFD byte,
// CRC-32 constants, descriptor bit positions and a descriptor builder.
package port_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP,
    COMMIT,
    WAIT_IDLE
  } rx_state_t;

  localparam logic [10:0] MIN_LEN     = 11'd64;
  localparam logic [10:0] MAX_LEN     = 11'd1518;
  localparam logic [7:0]  SFD         = 8'hD5;

  // CRC register runs MSB-first with the normal polynomial while data bits
  // enter LSB-first, so a good frame (FCS included) leaves this residue.
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam int unsigned CRC_ERR_BIT = 15;
  localparam int unsigned LEN_ERR_BIT = 14;
  localparam int unsigned LEN_MSB     = 10;

  function automatic logic [15:0] make_desc(input logic       crc_err,
                                            input logic       len_err,
                                            input logic [10:0] len);
    logic [15:0] d;
    d = '0;
    d[CRC_ERR_BIT] = crc_err;
    d[LEN_ERR_BIT] = len_err;
    d[LEN_MSB:0]   = len;
    return d;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// CRC-32 (IEEE 802.3) combinational next-state, one byte per cycle.
// Ports:
//   crc_in  [31:0] current CRC register
//   d       [7:0]  data byte, bit 0 is first on the wire
//   crc_out [31:0] register value after absorbing d
// The register itself lives in the instantiating block.
module crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);
  import port_rx_pkg::*;

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_out[31] ^ d[i]) begin
        crc_out = {crc_out[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_out = {crc_out[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data.
// Ports:
//   clk, rst_n         clock, asynchronous active-low flush
//   wr, din            write strobe and data
//   rd, dout           read strobe; dout valid the cycle after rd
//   full, empty, count occupancy status (count is 0..2^AW)
// A read and a write on the same cycle are both honoured: at full the read
// frees the slot the write takes; at empty the write data is forwarded
// straight to dout and nothing is stored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [WIDTH-1:0] mem [1 << AW];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             rd_en;
  logic             wr_en;
  logic             bypass;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  always_comb begin
    bypass = wr && rd && empty;
    rd_en  = rd && !empty;
    wr_en  = wr && !bypass && (!full || rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      if (bypass) begin
        dout <= din;
      end else if (rd_en) begin
        dout <= mem[rptr];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= din;
    end
  end

endmodule

// File: rtl/port_rx_frontend.sv
// Receive front end: strips preamble/SFD, stores frame bytes (FCS included)
// in a data FIFO and pushes one 16-bit descriptor per admitted frame
// {crc_err, len_err, 3'b000, len[10:0]} into a pointer FIFO.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_dv, rx_d, rx_er  PHY receive byte stream
//   rx_data_fifo_rd     data FIFO read; rx_data_fifo_dout valid next cycle
//   rx_ptr_fifo_rd      descriptor read; rx_ptr_fifo_dout valid next cycle
//   rx_ptr_fifo_empty   no descriptor available
//   drop_cnt            saturating count of frames refused at SFD
// Build option: define RX_CRC_CHECK_EN to build the CRC-32 checker;
// without it crc_err is constant 0 and no CRC logic exists.
module port_rx_frontend
  import port_rx_pkg::*;
#(
  parameter int unsigned DATA_AW = 12,
  parameter int unsigned PTR_AW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_d,
  input  logic        rx_er,
  input  logic        rx_data_fifo_rd,
  output logic [7:0]  rx_data_fifo_dout,
  input  logic        rx_ptr_fifo_rd,
  output logic [15:0] rx_ptr_fifo_dout,
  output logic        rx_ptr_fifo_empty,
  output logic [15:0] drop_cnt
);

  // A frame is admitted only if a maximum-length frame is guaranteed to fit.
  localparam logic [DATA_AW:0] ADMIT_LIMIT =
    (DATA_AW+1)'((1 << DATA_AW) - int'(MAX_LEN));

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [10:0]       len;
  logic              len_err;
  logic              crc_err;
  logic              data_wr;
  logic              ptr_wr;
  logic              frame_start;
  logic              drop_inc;
  logic              room;
  logic [15:0]       ptr_din;
  logic [DATA_AW:0]  data_cnt;
  logic              ptr_full;
  logic              data_full_unused;
  logic              data_empty_unused;
  logic [PTR_AW:0]   ptr_cnt_unused;

  assign room = (data_cnt <= ADMIT_LIMIT) && !ptr_full;

  // Reset always lands in WAIT_IDLE; with rx_dv low it falls through to IDLE
  // on the first clock, so a constant reset value suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    data_wr     = 1'b0;
    ptr_wr      = 1'b0;
    frame_start = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_dv) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_nxt = IDLE;
        end else if (rx_d == SFD) begin
          if (room) begin
            state_nxt   = DATA;
            frame_start = 1'b1;
          end else begin
            state_nxt = DROP;
            drop_inc  = 1'b1;
          end
        end
      end
      DATA: begin
        if (!rx_dv) begin
          state_nxt = COMMIT;
        end else if (len < MAX_LEN) begin
          data_wr = 1'b1;
        end
      end
      DROP: begin
        if (!rx_dv) state_nxt = IDLE;
      end
      COMMIT: begin
        ptr_wr    = 1'b1;
        // A byte arriving here is the next frame's first preamble byte.
        state_nxt = rx_dv ? PREAMBLE : IDLE;
      end
      WAIT_IDLE: begin
        if (!rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      len_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (frame_start) begin
        len     <= '0;
        len_err <= 1'b0;
      end else if (state == DATA) begin
        if (data_wr) begin
          len <= len + 11'd1;
        end
        // A byte refused for length, or a PHY error, taints the frame.
        if ((rx_dv && !data_wr) || rx_er) begin
          len_err <= 1'b1;
        end
      end
      if (drop_inc && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc;
  logic [31:0] crc_next;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .d       (rx_d),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (frame_start) begin
      crc <= CRC_INIT;
    end else if (data_wr) begin
      crc <= crc_next;
    end
  end

  assign crc_err = (crc != CRC_RESIDUE);
`else
  assign crc_err = 1'b0;
`endif

  assign ptr_din = make_desc(crc_err, len_err || (len < MIN_LEN), len);

  sync_fifo #(
    .WIDTH (8),
    .AW    (DATA_AW)
  ) u_data_fifo (
    .clk   (clk),
    .rst_n (!rst),
    .wr    (data_wr),
    .din   (rx_d),
    .rd    (rx_data_fifo_rd),
    .dout  (rx_data_fifo_dout),
    .full  (data_full_unused),
    .empty (data_empty_unused),
    .count (data_cnt)
  );

  sync_fifo #(
    .WIDTH (16),
    .AW    (PTR_AW)
  ) u_ptr_fifo (
    .clk   (clk),
    .rst_n (!rst),
    .wr    (ptr_wr),
    .din   (ptr_din),
    .rd    (rx_ptr_fifo_rd),
    .dout  (rx_ptr_fifo_dout),
    .full  (ptr_full),
    .empty (rx_ptr_fifo_empty),
    .count (ptr_cnt_unused)
  );

endmodule

// File: doc/port_rx_frontend.md
PORT_RX_FRONTEND -- requirements
Module: port_rx_frontend

Interface
REQ-001 Parameter DATA_AW, 12, data FIFO address width (4096 bytes).
REQ-002 Parameter PTR_AW, 4, pointer FIFO address width (16 entries).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_dv  input  1  receive byte valid; frame delimiter, high for preamble, SFD and frame bytes.
REQ-006 rx_d  input  8  receive byte.
REQ-007 rx_er  input  1  PHY receive error.
REQ-008 rx_data_fifo_rd  input  1  downstream data FIFO read.
REQ-009 rx_data_fifo_dout  output  8  data FIFO read data, valid the cycle after rd.
REQ-010 rx_ptr_fifo_rd  input  1  downstream pointer FIFO read.
REQ-011 rx_ptr_fifo_dout  output  16  frame descriptor.
REQ-012 rx_ptr_fifo_empty  output  1  no descriptor available.
REQ-013 drop_cnt  output  16  count of frames not admitted.

Function
REQ-014 States SHALL be IDLE, PREAMBLE, DATA, DROP, COMMIT, WAIT_IDLE.
- IDLE: rx_dv=1 -> PREAMBLE.
REQ-015 PREAMBLE SHALL discard bytes until 8'hD5.
- On 8'hD5, admission check: data FIFO count <= 2^DATA_AW-1518 and pointer FIFO not full -> DATA; else DROP and drop_cnt+1.
- rx_dv=0 before SFD -> IDLE, nothing written.
REQ-016 DATA SHALL write every byte after SFD, FCS included, into the data FIFO.
- Increment the 11-bit length counter per byte.
- Feed each byte to the CRC.
REQ-017 Once length reaches 1518, further bytes SHALL NOT be written, and the length-error flag SHALL be set.
REQ-018 rx_er=1 in DATA SHALL set the length-error flag; bytes are still written.
REQ-019 rx_dv falling in DATA SHALL enter COMMIT.
- COMMIT writes exactly one descriptor: {crc_err, len_err, 3'b000, len[10:0]}.
- Descriptor is visible (rx_ptr_fifo_empty=0) one cycle after the COMMIT write; COMMIT -> IDLE.
REQ-020 len_err SHALL also be set when len < 64.
REQ-021 Descriptor len SHALL equal exactly the number of bytes written for that frame, so a downstream reader consuming len bytes stays aligned.
REQ-022 DROP SHALL write nothing and return to IDLE when rx_dv=0.
REQ-023 drop_cnt SHALL saturate at 16'hFFFF.
REQ-024 A frame whose rx_dv stays low for only one cycle between frames SHALL be received normally: COMMIT and the next frame's PREAMBLE are not mutually exclusive.
- rx_dv=1 during COMMIT -> PREAMBLE.
REQ-025 Reads and writes on the same cycle SHALL be honoured on both FIFOs, including at full and empty boundaries.
- Overflow is impossible by the admission rule.

Reset
REQ-026 On rst, the module SHALL:
- set state to WAIT_IDLE (IDLE if rx_dv=0), length counter 0, flags 0, CRC 32'hFFFFFFFF, drop_cnt 0;
- flush both FIFOs;
- drive rx_ptr_fifo_empty=1 and rx_data_fifo_dout=0.
REQ-027 WAIT_IDLE SHALL ignore input until rx_dv=0, so a frame cut by mid-frame reset is never stored; then -> IDLE.

Configuration
REQ-028 With RX_CRC_CHECK_EN defined, CRC-32 SHALL be checked:
- register init 32'hFFFFFFFF at SFD;
- crc_err=1 unless the register equals residue 32'hC704DD7B after the last byte.
REQ-029 Without RX_CRC_CHECK_EN, no CRC logic SHALL be built and crc_err SHALL always be 0.

Structure
REQ-030 Package port_rx_pkg SHALL hold:
- state enum;
- MIN_LEN=64, MAX_LEN=1518, SFD=8'hD5, CRC_RESIDUE=32'hC704DD7B;
- descriptor bit positions (CRC_ERR_BIT=15, LEN_ERR_BIT=14, LEN_MSB=10).
REQ-031 Sub-module crc32_d8 (8-bit-per-cycle combinational next-state, registered in this block) SHALL implement the CRC.
- Both FIFOs are existing sync_fifo instances with rst_n driven by !rst.

Verification
REQ-032 Good 64-byte frame (7x55, D5, 60 payload, valid FCS) -> one descriptor 16'h0040; 64 bytes read back identical.
REQ-033 Same frame with one payload bit flipped (CRC_EN) -> descriptor 16'h8040; without macro -> 16'h0040.
REQ-034 Runt 40-byte frame -> 16'h4028; 1600-byte frame -> 16'h45EE (or 16'hC5EE with CRC_EN) and exactly 1518 bytes stored.
REQ-035 Data FIFO filled to 2600 bytes by unread frames, then a new frame -> no write, drop_cnt=1; after reading, next frame is accepted.
REQ-036 Back-to-back frames with one idle cycle -> two descriptors in order, data aligned.
REQ-037 rst asserted mid-frame with rx_dv held high -> rx_ptr_fifo_empty=1, no descriptor until the next complete frame after rx_dv=0.
